// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache.
// Hits are combinational. A miss issues one word request and fills the line
// when the controller answers. A flush abandons an outstanding miss through a
// one-cycle DRAIN state, which gives the controller time to see mem_valid low.
// Optional feature: define ICACHE_FWD_EN to forward the returning word
// (hit=1, inst=mem_din) in the completion cycle when if_pc matches the miss.
module icache #(
    parameter int unsigned LINE_BITS = 8,
    parameter int unsigned TAG_BITS  = 30 - LINE_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        hit,
    output logic [31:0] inst,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_enable,
    input  logic [31:0] mem_din
);

    localparam int unsigned LINES = 1 << LINE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [29:0]          miss_word;
    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    logic [LINE_BITS-1:0] idx;
    logic [LINE_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]  pc_tag;
    logic [TAG_BITS-1:0]  miss_tag;
    logic                 arr_hit_c;
    logic                 fwd_c;
    logic                 fill_c;
    logic                 unused_pc_lsb;

    assign idx           = if_pc[LINE_BITS+1:2];
    assign pc_tag        = if_pc[31:LINE_BITS+2];
    assign miss_idx      = miss_word[LINE_BITS-1:0];
    assign miss_tag      = miss_word[29:LINE_BITS];
    assign unused_pc_lsb = ^if_pc[1:0];

    // Array lookup: valid line whose tag matches the fetch address
    assign arr_hit_c = rdy & if_valid & valid[idx] & (tag_mem[idx] == pc_tag);

    // Line fill happens only on the completion pulse while a miss is pending
    assign fill_c = rdy & (state == ST_MISS) & mem_enable;

`ifdef ICACHE_FWD_EN
    // Forward the returning word to a fetch of the same word address
    assign fwd_c = rdy & if_valid & (state == ST_MISS) & mem_enable
                 & (if_pc[31:2] == miss_word);
`else
    assign fwd_c = 1'b0;
`endif

    // Hit/instruction outputs, array or forwarded word
    always_comb begin
        hit  = arr_hit_c | fwd_c;
        inst = data_mem[idx];
        if (fwd_c) begin
            inst = mem_din;
        end
    end

    // Request drops in the same cycle as completion or flush
    assign mem_valid = (state == ST_MISS) & ~mem_enable & ~flush;
    assign mem_addr  = {miss_word, 2'b00};

    // Miss FSM, miss address and valid bits; rdy=0 freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            miss_word <= '0;
            valid     <= '0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (if_valid && !hit && !flush) begin
                        miss_word <= if_pc[31:2];
                        state     <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (mem_enable) begin
                        valid[miss_idx] <= 1'b1;
                        state           <= ST_IDLE;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: written on fill, read asynchronously
    always_ff @(posedge clk) begin
        if (fill_c) begin
            data_mem[miss_idx] <= mem_din;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios followed by randomized fetch /
// flush / rdy / reset traffic, all checked against a behavioural model that
// tracks cached word addresses per index and one outstanding request.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        flush = 1'b0;
    logic        hit;
    logic [31:0] inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_enable = 1'b0;
    logic [31:0] mem_din = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .flush      (flush),
        .hit        (hit),
        .inst       (inst),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_enable (mem_enable),
        .mem_din    (mem_din)
    );

    // Model: per index, which word address is cached and its data
    bit          line_v    [256];
    logic [29:0] line_word [256];
    logic [31:0] line_data [256];
    bit          pending;
    bit          draining;
    logic [29:0] pend_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (line_v[i]) line_v[i] = 1'b0;
        pending   = 1'b0;
        draining  = 1'b0;
        pend_word = '0;
    endtask

    // One cycle: drive at negedge, check outputs, advance the model
    task automatic step(input logic rs, input logic r, input logic iv,
                        input logic [31:0] pc, input logic fl,
                        input logic me, input logic [31:0] din);
        logic [29:0] w;
        int          i;
        logic        ah;
        logic        fw;
        logic        eh;
        logic [31:0] ei;
        @(negedge clk);
        rst = rs; rdy = r; if_valid = iv; if_pc = pc;
        flush = fl; mem_enable = me; mem_din = din;
        #1;
        w = pc[31:2];
        i = int'(w[7:0]);
        if (!rs) begin
            model_reset();
            check("hit_in_reset", 32'(hit), 32'd0);
            check("mem_valid_in_reset", 32'(mem_valid), 32'd0);
            check("mem_addr_in_reset", mem_addr, 32'd0);
            return;
        end
        ah = r & iv & line_v[i] & (line_word[i] == w);
        fw = 1'b0;
`ifdef ICACHE_FWD_EN
        fw = r & iv & pending & me & (w == pend_word);
`endif
        eh = ah | fw;
        ei = fw ? din : line_data[i];
        check("hit", 32'(hit), 32'(eh));
        if (eh) check("inst", inst, ei);
        check("mem_valid", 32'(mem_valid), 32'(pending & ~me & ~fl));
        if (pending) check("mem_addr", mem_addr, {pend_word, 2'b00});
        if (r) begin
            if (pending) begin
                if (me) begin
                    line_v[int'(pend_word[7:0])]    = 1'b1;
                    line_word[int'(pend_word[7:0])] = pend_word;
                    line_data[int'(pend_word[7:0])] = din;
                    pending = 1'b0;
                end else if (fl) begin
                    pending  = 1'b0;
                    draining = 1'b1;
                end
            end else if (draining) begin
                draining = 1'b0;
            end else if (iv && !eh && !fl) begin
                pending   = 1'b1;
                pend_word = w;
            end
        end
    endtask

    task automatic go(input logic [31:0] pc, input logic fl, input logic me, input logic [31:0] din);
        step(1'b1, 1'b1, 1'b1, pc, fl, me, din);
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(1, 4)) << 10) | (32'($urandom_range(0, 3)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] pc;
        int          lat;
        logic        rs, r, iv, fl, me;
        logic [31:0] din;

        model_reset();
        step(1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 32'h5);

        // Cold miss then fill
        go(32'h1000, 0, 0, 0);         check("t1_cold_hit", 32'(hit), 0);
        go(32'h1000, 0, 0, 0);         check("t1_req", 32'(mem_valid), 1);
                                       check("t1_addr", mem_addr, 32'h1000);
        go(32'h1000, 0, 1, 32'h13);    check("t1_req_drop", 32'(mem_valid), 0);
        go(32'h1000, 0, 0, 0);         check("t1_hit", 32'(hit), 1);
                                       check("t1_inst", inst, 32'h13);

        // Conflict on the same index
        go(32'h1400, 0, 0, 0);         check("t2_conflict_miss", 32'(hit), 0);
        go(32'h1400, 0, 0, 0);
        go(32'h1400, 0, 1, 32'hAAAA_0001);
        go(32'h1400, 0, 0, 0);         check("t2_hit", 32'(hit), 1);
        go(32'h1000, 0, 0, 0);         check("t2_evicted", 32'(hit), 0);
        go(32'h1000, 0, 0, 0);
        go(32'h1000, 0, 1, 32'h13);

        // Flush two cycles into a miss
        go(32'h3000, 0, 0, 0);
        go(32'h3000, 0, 0, 0);
        go(32'h3000, 0, 0, 0);
        go(32'h3000, 1, 0, 0);         check("t3_flush_cycle", 32'(mem_valid), 0);
        go(32'h2000, 0, 0, 0);         check("t3_drain_cycle", 32'(mem_valid), 0);
        go(32'h2000, 0, 0, 0);         check("t3_detect_cycle", 32'(mem_valid), 0);
        go(32'h2000, 0, 0, 0);         check("t3_new_req", 32'(mem_valid), 1);
                                       check("t3_new_addr", mem_addr, 32'h2000);
        go(32'h2000, 0, 1, 32'h2222);
        go(32'h3000, 0, 0, 0);         check("t3_no_fill", 32'(hit), 0);
        go(32'h3000, 0, 0, 0);
        go(32'h3000, 0, 1, 32'h3333);

        // Completion and flush in the same cycle
        go(32'h4000, 0, 0, 0);
        go(32'h4000, 0, 0, 0);
        go(32'h4000, 1, 1, 32'h44);
        go(32'h4000, 0, 0, 0);         check("t4_hit", 32'(hit), 1);
                                       check("t4_inst", inst, 32'h44);

        // rdy low for three cycles mid-miss
        go(32'h5000, 0, 0, 0);
        go(32'h5000, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b0, '0);
            check("t5_frozen_hit", 32'(hit), 0);
            check("t5_frozen_addr", mem_addr, 32'h5000);
        end
        go(32'h5000, 0, 1, 32'h55);
        go(32'h5000, 0, 0, 0);         check("t5_hit", 32'(hit), 1);

        // Asynchronous reset mid-miss
        go(32'h6000, 0, 0, 0);
        go(32'h6000, 0, 0, 0);         check("t6_req", 32'(mem_valid), 1);
        #2 rst = 1'b0;
        #1 check("t6_async_drop", 32'(mem_valid), 0);
        step(1'b0, 1'b1, 1'b1, 32'h6000, 1'b0, 1'b0, '0);
        go(32'h1000, 0, 0, 0);         check("t6_lost_line", 32'(hit), 0);
        go(32'h1000, 0, 0, 0);
        go(32'h1000, 0, 1, 32'h13);

        // Randomized traffic with a latency-varying controller
        pc  = 32'h1000;
        lat = 0;
        for (int c = 0; c < 4000; c++) begin
            rs  = ($urandom_range(0, 399) != 0);
            r   = ($urandom_range(0, 9) != 0);
            iv  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) pc = rand_pc();
            fl  = ($urandom_range(0, 19) == 0);
            din = $urandom;
            me  = 1'b0;
            if (pending) begin
                if (lat == 0) me = 1'b1;
                else if (r) lat--;
            end else begin
                me  = ($urandom_range(0, 29) == 0);
                lat = $urandom_range(0, 4);
            end
            step(rs, r, iv, pc, fl, me, din);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
